// File: rtl/scr1_dmem_mailbox.sv
// ============================================================================
// scr1_dmem_mailbox
// ----------------------------------------------------------------------------
// Memory-mapped mailbox slave for one SCR1 dmem router port. The core pushes
// words into a TX FIFO and pops words from an RX FIFO. An external agent
// drains TX and fills RX through valid/ready streams.
//
// Register map (addr[3:0], upper address bits alias):
//   0x0 DATA    WR pushes TX, RD pops RX
//   0x4 STATUS  RO {rx_count @16, tx_count @8, rx_empty, rx_full,
//               tx_empty, tx_full}
//   0x8 CTRL    WO self-clearing, bit0 flush TX, bit1 flush RX (RD -> 0)
//   0xC IRQ_EN  RW, only when SCR1_MBOX_IRQ_EN is defined
//
// Optional feature macro: SCR1_MBOX_IRQ_EN
//   defined     -> IRQ_EN register present, irq registered from the enables
//   not defined -> irq tied low, offset 0xC answers RDY_ER
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   dmem_req/_req_ack      address phase (ack is high whenever out of reset)
//   dmem_cmd               0 = RD, 1 = WR
//   dmem_width             0 = BYTE, 1 = HWORD, 2 = WORD
//   dmem_addr/_wdata       byte address / write data
//   dmem_rdata/_resp       registered data phase, resp 0 = NOTRDY,
//                          1 = RDY_OK, 2 = RDY_ER
//   tx_valid/ready/data    TX stream towards the external agent
//   rx_valid/ready/data    RX stream from the external agent
//   irq                    mailbox interrupt
// ============================================================================

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_dmem_mailbox #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          dmem_req,
   output logic                          dmem_req_ack,
   input  logic                          dmem_cmd,
   input  logic [1:0]                    dmem_width,
   input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr,
   input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata,
   output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata,
   output logic [1:0]                    dmem_resp,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [31:0]                   tx_data,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   input  logic [31:0]                   rx_data,
   output logic                          irq
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int AW    = `SCR1_DMEM_AWIDTH;
   localparam int DW    = `SCR1_DMEM_DWIDTH;

   // SCR1 dmem encodings
   localparam logic       CMD_WR     = 1'b1;
   localparam logic [1:0] WIDTH_WORD = 2'b10;
   localparam logic [1:0] RESP_NOTRDY = 2'b00;
   localparam logic [1:0] RESP_RDY_OK = 2'b01;
   localparam logic [1:0] RESP_RDY_ER = 2'b10;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_IRQ_EN = 2'd3
   } reg_e;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   // -------------------------------------------------------------------------
   // FIFO state
   // -------------------------------------------------------------------------
   logic [31:0]      tx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [CNT_W-1:0] tx_count;
   logic             tx_full, tx_empty;

   logic [31:0]      rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [CNT_W-1:0] rx_count;
   logic             rx_full, rx_empty;

   assign tx_full  = (tx_count == CNT_FULL);
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == CNT_FULL);
   assign rx_empty = (rx_count == '0);

   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_mem[tx_rd_ptr];
   assign rx_ready = ~rx_full;

   logic tx_pop_ext, rx_push_ext;
   assign tx_pop_ext  = tx_valid & tx_ready;
   assign rx_push_ext = rx_valid & rx_ready;

   // The slave never stalls; acceptance is simply dmem_req out of reset.
   assign dmem_req_ack = rst_n;

`ifdef SCR1_MBOX_IRQ_EN
   logic [1:0] irq_en_q;
   logic       irq_q;
`endif

   // -------------------------------------------------------------------------
   // Request decode (acceptance cycle)
   // -------------------------------------------------------------------------
   reg_e          reg_sel;
   logic          req_acc, is_wr, req_err, req_ok;
   logic          tx_push_core, rx_pop_core, tx_flush, rx_flush, irq_en_we;
   logic [DW-1:0] status_word;
   logic [DW-1:0] rdata_d;
   logic [1:0]    resp_d;

   assign reg_sel = reg_e'(dmem_addr[3:2]);
   assign req_acc = dmem_req & dmem_req_ack;
   assign is_wr   = (dmem_cmd == CMD_WR);

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      status_word                = '0;
      status_word[0]             = tx_full;
      status_word[1]             = tx_empty;
      status_word[2]             = rx_full;
      status_word[3]             = rx_empty;
      status_word[8  +: CNT_W]   = tx_count;
      status_word[16 +: CNT_W]   = rx_count;
   end

   always_comb begin
      req_err = (dmem_width != WIDTH_WORD) || (dmem_addr[1:0] != 2'b00);
      unique case (reg_sel)
         REG_DATA:   if (is_wr ? tx_full : rx_empty) req_err = 1'b1;
         REG_STATUS: if (is_wr) req_err = 1'b1;
         REG_CTRL:   ;
         REG_IRQ_EN: begin
`ifndef SCR1_MBOX_IRQ_EN
            req_err = 1'b1;
`endif
         end
         default:    req_err = 1'b1;
      endcase
   end

   assign req_ok = req_acc & ~req_err;

   // TX-full rejection uses the pre-edge count, so a same-cycle external pop
   // does not rescue a write to a full FIFO.
   assign tx_push_core = req_ok &  is_wr & (reg_sel == REG_DATA);
   assign rx_pop_core  = req_ok & ~is_wr & (reg_sel == REG_DATA);
   assign tx_flush     = req_ok &  is_wr & (reg_sel == REG_CTRL) & dmem_wdata[0];
   assign rx_flush     = req_ok &  is_wr & (reg_sel == REG_CTRL) & dmem_wdata[1];
   assign irq_en_we    = req_ok &  is_wr & (reg_sel == REG_IRQ_EN);

   always_comb begin
      rdata_d = '0;
      if (req_ok && !is_wr) begin
         unique case (reg_sel)
            REG_DATA:   rdata_d = DW'(rx_mem[rx_rd_ptr]);
            REG_STATUS: rdata_d = status_word;
`ifdef SCR1_MBOX_IRQ_EN
            REG_IRQ_EN: rdata_d = DW'(irq_en_q);
`endif
            default:    rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      resp_d = RESP_NOTRDY;
      if (req_acc) resp_d = req_err ? RESP_RDY_ER : RESP_RDY_OK;
   end

   // -------------------------------------------------------------------------
   // Response register (fixed latency of one cycle)
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_resp  <= RESP_NOTRDY;
         dmem_rdata <= '0;
      end else begin
         dmem_resp  <= resp_d;
         dmem_rdata <= rdata_d;
      end
   end

   // -------------------------------------------------------------------------
   // TX FIFO: core pushes, external agent pops
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else if (tx_flush) begin
         // Flush wins over any external pop in the same cycle.
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push_core) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop_ext)   tx_rd_ptr <= tx_rd_ptr + 1'b1;
         unique case ({tx_push_core, tx_pop_ext})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
      end
   end

   // NOTE: storage arrays carry no reset; the pointers and counts define
   // which entries are meaningful, so clearing the data would only cost area.
   always_ff @(posedge clk) begin
      if (tx_push_core) tx_mem[tx_wr_ptr] <= dmem_wdata[31:0];
   end

   // -------------------------------------------------------------------------
   // RX FIFO: external agent pushes, core pops
   // -------------------------------------------------------------------------
   logic rx_push_eff;
   assign rx_push_eff = rx_push_ext & ~rx_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else if (rx_flush) begin
         // An incoming word handshaked during a flush is discarded.
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push_eff) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop_core) rx_rd_ptr <= rx_rd_ptr + 1'b1;
         unique case ({rx_push_eff, rx_pop_core})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push_eff) rx_mem[rx_wr_ptr] <= rx_data;
   end

   // -------------------------------------------------------------------------
   // Interrupt
   // -------------------------------------------------------------------------
`ifdef SCR1_MBOX_IRQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en_q <= 2'b00;
         irq_q    <= 1'b0;
      end else begin
         if (irq_en_we) irq_en_q <= dmem_wdata[1:0];
         irq_q <= (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);
      end
   end
   assign irq = irq_q;
`else
   assign irq = 1'b0;
   logic unused_irq_en_we;
   assign unused_irq_en_we = irq_en_we;
`endif

   // Upper address bits are aliased and upper write data bits beyond the
   // FIFO width are not stored.
   logic unused_inputs;
   assign unused_inputs = ^{dmem_addr[AW-1:4], dmem_wdata};

endmodule

// File: tb/tb_scr1_dmem_mailbox.sv
// ============================================================================
// tb_scr1_dmem_mailbox
// ----------------------------------------------------------------------------
// Directed self-checking bench for scr1_dmem_mailbox (FIFO_DEPTH = 4).
// Requests are presented right after a rising edge; the registered response
// is sampled 1 ns after the accepting edge.
// ============================================================================
`timescale 1ns/1ps

module tb_scr1_dmem_mailbox;

   localparam logic       RD = 1'b0, WR = 1'b1;
   localparam logic [1:0] W_BYTE = 2'd0, W_WORD = 2'd2;
   localparam logic [1:0] NOTRDY = 2'd0, RDY_OK = 2'd1, RDY_ER = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dmem_req;
   logic        dmem_req_ack;
   logic        dmem_cmd;
   logic [1:0]  dmem_width;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic [1:0]  dmem_resp;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] rx_data;
   logic        irq;

   int n_checks = 0;
   int n_fails  = 0;

   scr1_dmem_mailbox #(.FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dmem_req     (dmem_req),
      .dmem_req_ack (dmem_req_ack),
      .dmem_cmd     (dmem_cmd),
      .dmem_width   (dmem_width),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_resp    (dmem_resp),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one request for one cycle; returns 1 ns after the accepting edge,
   // when the registered response of that request is visible.
   task automatic issue(input logic cmd, input logic [1:0] width,
                        input logic [31:0] addr, input logic [31:0] wdata);
      dmem_req   = 1'b1;
      dmem_cmd   = cmd;
      dmem_width = width;
      dmem_addr  = addr;
      dmem_wdata = wdata;
      @(posedge clk);
      #1;
      dmem_req   = 1'b0;
   endtask

   task automatic check_resp(input string tag, input logic [1:0] resp,
                             input logic [31:0] rdata);
      check({tag, " resp"},  {30'd0, dmem_resp}, {30'd0, resp});
      check({tag, " rdata"}, dmem_rdata, rdata);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      dmem_req   = 1'b0;
      dmem_cmd   = RD;
      dmem_width = W_WORD;
      dmem_addr  = '0;
      dmem_wdata = '0;
      tx_ready   = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = '0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      check("rst resp",     {30'd0, dmem_resp}, {30'd0, NOTRDY});
      check("rst rdata",    dmem_rdata, 32'h0);
      check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst rx_ready", {31'd0, rx_ready}, 32'd1);
      check("rst irq",      {31'd0, irq}, 32'd0);
      check("rst ack",      {31'd0, dmem_req_ack}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("ack high", {31'd0, dmem_req_ack}, 32'd1);
      tick();
      check("idle notrdy", {30'd0, dmem_resp}, {30'd0, NOTRDY});

      // ---------------- initial STATUS ----------------
      issue(RD, W_WORD, 32'h4, '0);
      check_resp("status0", RDY_OK, 32'h0000_000A);

      // ---------------- fill TX back-to-back ----------------
      issue(WR, W_WORD, 32'h0, 32'h11);
      check_resp("tx wr1", RDY_OK, 32'h0);
      check("tx_valid rise", {31'd0, tx_valid}, 32'd1);
      check("tx head 11", tx_data, 32'h11);
      issue(WR, W_WORD, 32'h0, 32'h22);
      check_resp("tx wr2", RDY_OK, 32'h0);
      issue(WR, W_WORD, 32'h0, 32'h33);
      check_resp("tx wr3", RDY_OK, 32'h0);
      issue(WR, W_WORD, 32'h0, 32'h44);
      check_resp("tx wr4", RDY_OK, 32'h0);
      issue(WR, W_WORD, 32'h0, 32'h55);
      check_resp("tx wr5 full", RDY_ER, 32'h0);
      issue(RD, W_WORD, 32'h4, '0);
      check_resp("status tx full", RDY_OK, 32'h0000_0409);

      // ---------------- WR to full TX with simultaneous pop ----------------
      tx_ready = 1'b1;
      issue(WR, W_WORD, 32'h0, 32'h66);
      tx_ready = 1'b0;
      check_resp("tx full wr+pop", RDY_ER, 32'h0);
      check("tx head 22", tx_data, 32'h22);
      issue(RD, W_WORD, 32'h4, '0);
      check_resp("status tx 3", RDY_OK, 32'h0000_0308);

      // ---------------- drain TX in order ----------------
      tx_ready = 1'b1;
      check("drain v0", {31'd0, tx_valid}, 32'd1);
      check("drain d0", tx_data, 32'h22);
      tick();
      check("drain v1", {31'd0, tx_valid}, 32'd1);
      check("drain d1", tx_data, 32'h33);
      tick();
      check("drain v2", {31'd0, tx_valid}, 32'd1);
      check("drain d2", tx_data, 32'h44);
      tick();
      check("tx_valid fall", {31'd0, tx_valid}, 32'd0);
      tx_ready = 1'b0;

      // ---------------- simultaneous core push / external pop ----------------
      issue(WR, W_WORD, 32'h0, 32'h77);
      check_resp("tx wr 77", RDY_OK, 32'h0);
      tx_ready = 1'b1;
      issue(WR, W_WORD, 32'h0, 32'h88);
      tx_ready = 1'b0;
      check_resp("tx push+pop", RDY_OK, 32'h0);
      check("tx head 88", tx_data, 32'h88);
      issue(RD, W_WORD, 32'h4, '0);
      check_resp("status push+pop", RDY_OK, 32'h0000_0108);

      // ---------------- RX path ----------------
      check("rx_ready empty", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b1;
      rx_data  = 32'hA5A5_0001;
      tick();
      rx_data  = 32'hA5A5_0002;
      tick();
      rx_valid = 1'b0;
      issue(RD, W_WORD, 32'h0, '0);
      check_resp("rx rd1", RDY_OK, 32'hA5A5_0001);
      issue(RD, W_WORD, 32'h0, '0);
      check_resp("rx rd2", RDY_OK, 32'hA5A5_0002);
      issue(RD, W_WORD, 32'h0, '0);
      check_resp("rx rd empty", RDY_ER, 32'h0);
      tick();
      check("idle after rd", {30'd0, dmem_resp}, {30'd0, NOTRDY});

      // ---------------- fill RX to full ----------------
      for (int i = 0; i < 4; i++) begin
         rx_valid = 1'b1;
         rx_data  = 32'hB0 + i;
         tick();
      end
      check("rx_ready full", {31'd0, rx_ready}, 32'd0);
      rx_data = 32'hDEAD_BEEF;   // offered while full, must be ignored
      tick();
      rx_valid = 1'b0;
      issue(RD, W_WORD, 32'h4, '0);
      check_resp("status rx full", RDY_OK, 32'h0004_0104);

      // ---------------- error responses, no state change ----------------
      issue(WR, W_BYTE, 32'h0, 32'h99);
      check_resp("byte wr", RDY_ER, 32'h0);
      issue(WR, W_WORD, 32'h4, 32'hFFFF_FFFF);
      check_resp("wr status", RDY_ER, 32'h0);
      issue(RD, W_WORD, 32'h2, '0);
      check_resp("misaligned rd", RDY_ER, 32'h0);
      issue(RD, W_WORD, 32'h4, '0);
      check_resp("status after err", RDY_OK, 32'h0004_0104);
      check("tx head kept", tx_data, 32'h88);

      // aliased DATA read pops the RX head
      issue(RD, W_WORD, 32'hF001_0000, '0);
      check_resp("alias rd data", RDY_OK, 32'h0000_00B0);
      issue(RD, W_WORD, 32'hF001_0004, '0);
      check_resp("alias status", RDY_OK, 32'h0003_0100);

      // ---------------- CTRL ----------------
      issue(RD, W_WORD, 32'h8, '0);
      check_resp("rd ctrl", RDY_OK, 32'h0);
      tx_ready = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 32'hCAFE_F00D;
      issue(WR, W_WORD, 32'h8, 32'h3);
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      check_resp("flush", RDY_OK, 32'h0);
      check("flush tx_valid", {31'd0, tx_valid}, 32'd0);
      check("flush rx_ready", {31'd0, rx_ready}, 32'd1);
      issue(RD, W_WORD, 32'h4, '0);
      check_resp("status flushed", RDY_OK, 32'h0000_000A);

      // ---------------- IRQ ----------------
`ifdef SCR1_MBOX_IRQ_EN
      issue(WR, W_WORD, 32'hC, 32'h1);
      check_resp("wr irq_en", RDY_OK, 32'h0);
      issue(RD, W_WORD, 32'hC, '0);
      check_resp("rd irq_en", RDY_OK, 32'h1);
      check("irq idle", {31'd0, irq}, 32'd0);
      rx_valid = 1'b1;
      rx_data  = 32'h0000_1234;
      tick();
      rx_valid = 1'b0;
      check("irq not yet", {31'd0, irq}, 32'd0);
      tick();
      check("irq rx", {31'd0, irq}, 32'd1);
      issue(RD, W_WORD, 32'h0, '0);
      check_resp("irq rd data", RDY_OK, 32'h0000_1234);
      check("irq hold", {31'd0, irq}, 32'd1);
      tick();
      check("irq cleared", {31'd0, irq}, 32'd0);
      issue(WR, W_WORD, 32'hC, 32'h2);
      tick();
      check("irq tx empty", {31'd0, irq}, 32'd1);
      issue(WR, W_WORD, 32'hC, 32'h0);
      tick();
      check("irq disabled", {31'd0, irq}, 32'd0);
`else
      issue(RD, W_WORD, 32'hC, '0);
      check_resp("rd 0xC", RDY_ER, 32'h0);
      issue(WR, W_WORD, 32'hC, 32'h3);
      check_resp("wr 0xC", RDY_ER, 32'h0);
      rx_valid = 1'b1;
      rx_data  = 32'h0000_1234;
      tick();
      rx_valid = 1'b0;
      tick();
      check("irq tied low", {31'd0, irq}, 32'd0);
      issue(RD, W_WORD, 32'h0, '0);
      check_resp("rd data no irq", RDY_OK, 32'h0000_1234);
`endif

      // ---------------- reset mid-transaction ----------------
      dmem_req   = 1'b1;
      dmem_cmd   = WR;
      dmem_width = W_WORD;
      dmem_addr  = 32'h0;
      dmem_wdata = 32'h5A;
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      dmem_req = 1'b0;
      check("rst mid resp",     {30'd0, dmem_resp}, {30'd0, NOTRDY});
      check("rst mid tx_valid", {31'd0, tx_valid}, 32'd0);
      rst_n = 1'b1;
      issue(RD, W_WORD, 32'h4, '0);
      check_resp("status after rst", RDY_OK, 32'h0000_000A);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
